// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter serialising N requesters' set/reset masks onto one shared
// bank of W set/reset flip-flops, with read-back verification after every command.
//
// state | meaning
// IDLE  | waiting for a request; picks the next requester round-robin from ptr
// APPLY | drives the conflict-free S/R lines to the bank for one cycle
// CHECK | compares the bank read-back with the applied command, registers ERR
// DONE  | pulses ACK/ERR to the granted requester, advances ptr
module sr_bank_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     REQ,
    input  logic [N*W-1:0]   S_MASK,
    input  logic [N*W-1:0]   R_MASK,
    input  logic [W-1:0]     Q_IN,
    output logic [W-1:0]     S_BUS,
    output logic [W-1:0]     R_BUS,
    output logic [N-1:0]     GNT,
    output logic [N-1:0]     ACK,
    output logic             ERR,
    output logic             BUSY
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [W-1:0]    smask;
    logic [W-1:0]    rmask;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;
    logic [W-1:0]    pick_s;
    logic [W-1:0]    pick_r;
    logic            mismatch;
    logic            conflict;
    logic [PW-1:0]   next_ptr;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % N);
            if (REQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_s   = S_MASK[int'(pick_idx)*W +: W];
    assign pick_r   = R_MASK[int'(pick_idx)*W +: W];
    assign next_ptr = PW'((int'(gnt_idx) + 1) % N);

    // Conflicting bits were never driven, so only the driven bits are read back.
    assign mismatch = |((smask & ~rmask) & ~Q_IN) | |((rmask & ~smask) & Q_IN);
    assign conflict = |(smask & rmask);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            smask   <= '0;
            rmask   <= '0;
            S_BUS   <= '0;
            R_BUS   <= '0;
            GNT     <= '0;
            ACK     <= '0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        smask         <= pick_s;
                        rmask         <= pick_r;
                        gnt_idx       <= pick_idx;
                        GNT           <= '0;
                        GNT[pick_idx] <= 1'b1;
                        S_BUS         <= pick_s & ~pick_r;
                        R_BUS         <= pick_r & ~pick_s;
                        BUSY          <= 1'b1;
                        state         <= APPLY;
                    end
                end
                APPLY: begin
                    S_BUS <= '0;
                    R_BUS <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    ACK   <= GNT;
                    ERR   <= mismatch | conflict;
                    state <= DONE;
                end
                DONE: begin
                    ACK   <= '0;
                    ERR   <= 1'b0;
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Bench for sr_bank_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the arbiter and the bank.
module tb_sr_bank_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic             CLK;
    logic             RST_N;
    logic [N-1:0]     REQ;
    logic [N*W-1:0]   S_MASK;
    logic [N*W-1:0]   R_MASK;
    logic [W-1:0]     Q_IN;
    logic [W-1:0]     S_BUS;
    logic [W-1:0]     R_BUS;
    logic [N-1:0]     GNT;
    logic [N-1:0]     ACK;
    logic             ERR;
    logic             BUSY;

    sr_bank_arbiter #(.N(N), .W(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .S_MASK(S_MASK), .R_MASK(R_MASK),
        .Q_IN(Q_IN), .S_BUS(S_BUS), .R_BUS(R_BUS), .GNT(GNT), .ACK(ACK),
        .ERR(ERR), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Flip-flop bank: no reset, updates from whatever is on the S/R lines.
    logic [W-1:0] bank;
    logic         corrupt;
    assign Q_IN = corrupt ? '0 : bank;
    always @(posedge CLK) bank <= (bank | S_BUS) & ~R_BUS;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: a command is granted, then lives for three cycles.
    int            m_age;
    int            m_ptr;
    int            m_cur;
    logic [W-1:0]  m_s, m_r, ds, dr;
    logic          m_err;
    logic [W-1:0]  e_s, e_r;
    logic [N-1:0]  e_gnt, e_ack;
    logic          e_err, e_busy;
    bit            found;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_age = 0;
            m_ptr = 0;
        end else if (m_age == 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && REQ[(m_ptr + k) % N]) begin
                    found = 1;
                    m_cur = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_s   = S_MASK[m_cur*W +: W];
                m_r   = R_MASK[m_cur*W +: W];
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_age == 2) begin
            ds    = m_s & ~m_r;
            dr    = m_r & ~m_s;
            m_err = ((m_s & m_r) != 0) || ((Q_IN & ds) != ds) || ((Q_IN & dr) != 0);
            m_age = 3;
        end else begin
            m_ptr = (m_cur + 1) % N;
            m_age = 0;
        end
        e_busy = (m_age != 0);
        e_gnt  = e_busy ? N'(1) << m_cur : '0;
        e_s    = (m_age == 1) ? (m_s & ~m_r) : '0;
        e_r    = (m_age == 1) ? (m_r & ~m_s) : '0;
        e_ack  = (m_age == 3) ? N'(1) << m_cur : '0;
        e_err  = (m_age == 3) ? m_err : 1'b0;
    end

    bit chk_en = 0;
    always @(negedge CLK) begin
        if (chk_en) begin
            check("S_BUS", S_BUS, e_s);
            check("R_BUS", R_BUS, e_r);
            check("GNT", GNT, e_gnt);
            check("ACK", ACK, e_ack);
            check("ERR", ERR, e_err);
            check("BUSY", BUSY, e_busy);
        end
    end

    int           ack_cyc[$];
    logic [N-1:0] ack_val[$];
    int           busy_cnt;
    int           wait_cnt[N];

    initial begin
        RST_N = 1'b0; REQ = '0; S_MASK = '0; R_MASK = '0; corrupt = 1'b0;
        bank <= '0;
        @(negedge CLK);
        chk_en = 1;

        // Reset then single set from requester 0.
        @(negedge CLK);
        check("rst_busy", BUSY, 1'b0);
        check("rst_gnt", GNT, '0);
        RST_N = 1'b1; REQ = 4'b0001; S_MASK[7:0] = 8'hA5;
        busy_cnt = 0;
        @(negedge CLK); busy_cnt += int'(BUSY);
        check("t1_sbus", S_BUS, 8'hA5);
        @(negedge CLK); busy_cnt += int'(BUSY);
        check("t1_qin", Q_IN, 8'hA5);
        @(negedge CLK); busy_cnt += int'(BUSY);
        check("t1_ack", ACK, 4'b0001);
        check("t1_err", ERR, 1'b0);
        REQ = '0;
        @(negedge CLK); busy_cnt += int'(BUSY);
        check("t1_busy_cycles", busy_cnt, 3);

        // Round-robin fairness with all requesters held high.
        RST_N = 1'b0; S_MASK = '0;
        @(negedge CLK);
        RST_N = 1'b1; REQ = 4'b1111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (ACK != 0) begin
                ack_cyc.push_back(i);
                ack_val.push_back(ACK);
            end
        end
        REQ = '0;
        check("rr_count", ack_cyc.size(), 5);
        for (int k = 0; k < 5 && k < ack_cyc.size(); k++) begin
            check("rr_ack", ack_val[k], N'(1) << (k % N));
            check("rr_cycle", ack_cyc[k], 3 + 4 * k);
        end

        // Conflict on requester 2: bits 5:4 are both set and reset.
        bank <= 8'h3C;
        REQ = 4'b0100; S_MASK[23:16] = 8'hF0; R_MASK[23:16] = 8'h30;
        @(negedge CLK);
        check("cf_sbus", S_BUS, 8'hC0);
        check("cf_rbus", R_BUS, 8'h00);
        @(negedge CLK);
        check("cf_bank", bank, 8'hFC);
        @(negedge CLK);
        check("cf_ack", ACK, 4'b0100);
        check("cf_err", ERR, 1'b1);
        REQ = '0; R_MASK = '0; S_MASK = '0;
        @(negedge CLK);

        // Read-back failure: Q_IN forced low during CHECK.
        bank <= '0;
        REQ = 4'b0001; S_MASK[7:0] = 8'h01;
        @(negedge CLK);
        @(negedge CLK);
        corrupt = 1'b1;
        @(negedge CLK);
        corrupt = 1'b0;
        check("rb_ack", ACK, 4'b0001);
        check("rb_err", ERR, 1'b1);
        REQ = '0;
        @(negedge CLK);

        // Reset during CHECK aborts the command; requester 3 served next.
        REQ = 4'b0001; S_MASK = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("mr_outs", {S_BUS, R_BUS, GNT, ACK, ERR, BUSY}, '0);
        RST_N = 1'b1; REQ = 4'b1000;
        @(negedge CLK);
        check("mr_gnt", GNT, 4'b1000);
        @(negedge CLK);
        @(negedge CLK);
        check("mr_ack", ACK, 4'b1000);
        REQ = '0;
        @(negedge CLK);

        // Mask change after grant is ignored.
        bank <= '0;
        REQ = 4'b0010; S_MASK[15:8] = 8'h0F;
        @(negedge CLK);
        S_MASK[15:8] = 8'hFF;
        check("mc_sbus", S_BUS, 8'h0F);
        @(negedge CLK);
        check("mc_bank", bank, 8'h0F);
        @(negedge CLK);
        check("mc_ack", ACK, 4'b0010);
        REQ = '0;
        @(negedge CLK);

        // Randomized traffic with sparse masks, glitches on Q_IN and rare resets.
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (!RST_N) wait_cnt[i] = 0;
                else if (ACK[i]) begin
                    check("fair_wait", wait_cnt[i] <= N - 1, 1'b1);
                    wait_cnt[i] = 0;
                end else if (ACK != 0 && REQ[i]) wait_cnt[i]++;
                else if (!REQ[i] && !GNT[i]) wait_cnt[i] = 0;
            end
            RST_N   = ($urandom_range(0, 299) != 0);
            corrupt = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                if (REQ[i]) begin
                    if (ACK[i] && $urandom_range(0, 1) == 1) REQ[i] = 1'b0;
                    else if (GNT[i] && $urandom_range(0, 49) == 0) REQ[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    REQ[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) begin
                    S_MASK[i*W +: W] = W'($urandom & $urandom);
                    R_MASK[i*W +: W] = W'($urandom & $urandom & $urandom);
                end
            end
        end

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Round-robin command arbiter that shares one bank of W clocked set/reset flip-flops between N requesters. Each requester posts a set mask and a reset mask. The arbiter serialises the commands onto the bank's S/R lines and never drives S=R=1 onto any bit. After each command it reads the bank back and returns a per-requester acknowledge with an error flag. It sits between the control requesters and the flip-flop bank, and shares that bank's clock.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, width of the flip-flop bank in bits

- CLK  in  1  single clock; every register updates on its rising edge
- RST_N  in  1  reset, synchronous, active-low
- REQ  in  N  per-requester command request; level, held until ACK
- S_MASK  in  N*W  set masks; requester i occupies bits [i*W +: W]
- R_MASK  in  N*W  reset masks; same packing as S_MASK
- Q_IN  in  W  current Q outputs of the bank, used for read-back
- S_BUS  out  W  set lines to the bank
- R_BUS  out  W  reset lines to the bank
- GNT  out  N  one-hot grant; held from APPLY through DONE
- ACK  out  N  one-hot, one-cycle completion pulse to the granted requester
- ERR  out  1  valid only with ACK: the command had a conflict or failed read-back
- BUSY  out  1  high whenever the state is not IDLE

## Operation
- State machine states: IDLE, APPLY, CHECK, DONE. All four are registered.
- **IDLE:**
  - If any REQ bit is high, pick the first requester with REQ high, searching from ptr upward modulo N.
  - Latch that requester's S_MASK and R_MASK slices into smask/rmask.
  - Set the one-hot gnt register. Go to APPLY.
  - If no REQ bit is high, stay in IDLE.
- **APPLY (exactly 1 cycle):**
  - S_BUS = smask & ~rmask.
  - R_BUS = rmask & ~smask.
  - Go to CHECK.
- **CHECK (1 cycle):**
  - The bank has updated at the end of APPLY.
  - mismatch = OR over bits of (S_BUS bits with Q_IN=0) | (R_BUS bits with Q_IN=1).
  - conflict = |(smask & rmask).
  - Register err = mismatch | conflict.
  - Go to DONE.
- **DONE (1 cycle):**
  - ACK = gnt.
  - ERR = err.
  - ptr <= (index of gnt + 1) mod N.
  - Go to IDLE.
- S_BUS and R_BUS are zero in every state except APPLY. The bank therefore holds its value whenever the arbiter is idle.
- Conflicting bits (S=R=1 in the masks) are never driven. They keep their old value and cause ERR=1.
- Empty command (both masks zero): the command still sequences through all states and completes with ERR=0.
- Mask or REQ changes after the grant edge have no effect on the command in flight.
- If REQ drops after grant, the command still completes and ACK is still pulsed.
- A requester whose REQ is still high in the IDLE cycle after its ACK is treated as a new request. Round-robin priority applies to it as to any other requester.

## Timing
- Latency: REQ seen in IDLE at cycle t gives APPLY at t+1, CHECK at t+2, and ACK/ERR at t+3.
- Throughput: at most one command per 4 cycles. Back-to-back commands have IDLE at t+4 and APPLY at t+5.
- GNT is high for cycles t+1..t+3. BUSY is high for t+1..t+3.
- ACK and ERR are registered outputs and are glitch-free. ERR is 0 whenever ACK is 0.
- Round-robin pointer:
  - ptr resets to 0.
  - After servicing requester k, requester k has the lowest priority.
  - No requester waits more than N-1 commands.
- Reset values when RST_N=0 at an edge:
  - Outputs: S_BUS=0, R_BUS=0, GNT=0, ACK=0, ERR=0, BUSY=0.
  - Internal registers: state=IDLE, ptr=0, smask=0, rmask=0, err=0.
- Reset mid-command (any state):
  - The command is aborted and no ACK is issued.
  - If reset is asserted during APPLY, the bank still updates at that edge because the bank has no reset.
  - The requester must re-issue the command after reset.
- Q_IN is sampled only in CHECK. Its value in other states is ignored.

## Test plan
- **Reset then single set:** N=4, W=8, RST_N low for 2 cycles, then REQ=0001, S_MASK[7:0]=8'hA5, R_MASK=0, bank initially 8'h00. Required: S_BUS=8'hA5 in APPLY, Q_IN=8'hA5 in CHECK, ACK=0001 with ERR=0 exactly 3 cycles after the request cycle, BUSY high for 3 cycles.
- **Round-robin fairness:** REQ=1111 held continuously with all masks zero. Required: ACK sequence 0001, 0010, 0100, 1000, 0001, one ACK every 4 cycles.
- **Conflict:** requester 2 with S_MASK=8'hF0 and R_MASK=8'h30, bank initially 8'h3C. Required: S_BUS=8'hC0, R_BUS=8'h00, bank becomes 8'hFC, ACK=0100 with ERR=1.
- **Read-back failure:** bench forces Q_IN=8'h00 during CHECK after S_MASK=8'h01. Required: ERR=1 with ACK.
- **Reset mid-command:** RST_N low during CHECK. Required: no ACK, all outputs 0 at the next cycle. A subsequent request from requester 3 is served first, because ptr=0 and requester 3 is the only requester.
- **Mask change after grant:** requester 1 changes S_MASK from 8'h0F to 8'hFF in the APPLY cycle. Required: S_BUS=8'h0F, and the bank updates only the low nibble.
